// File: rtl/frame_sequencer_pkg.sv
// Frame sequencer shared types: FSM state enum, frame geometry constants.
package frame_sequencer_pkg;

    localparam int FRAME_CYCLES_DEFAULT = 128;
    localparam int ENC_FRAME_W          = 128;
    localparam int DEC_FRAME_W          = 384;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_e;

    // Abort is only honoured while a frame is actually being pushed to the slice.
    function automatic logic isFrameActive(input seq_state_e s);
        return (s == ST_LOAD) || (s == ST_RUN) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/param_def.sv
// Code-rate encodings shared by the frame sequencer, its slice and the parent.
package param_def;

    localparam int CODE_RATE_W = 1;
    localparam logic [CODE_RATE_W-1:0] CODE_RATE_2 = 1'b0;
    localparam logic [CODE_RATE_W-1:0] CODE_RATE_3 = 1'b1;

endpackage

// File: rtl/frame_sequencer.sv
// Frame sequencer: latches one frame, then walks the slice through LOAD/RUN/DRAIN/DONE.
// Optional build macro FRAME_SEQ_CNT_EN adds a 16-bit completed-frame counter output.
module frame_sequencer
    import frame_sequencer_pkg::*;
    import param_def::*;
#(
    parameter int FRAME_CYCLES = FRAME_CYCLES_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_frame_valid,
    output logic                   o_frame_ready,
    input  logic [CODE_RATE_W-1:0] i_code_rate,
    input  logic [ENC_FRAME_W-1:0] i_enc_frame,
    input  logic [DEC_FRAME_W-1:0] i_dec_frame,
    input  logic                   i_abort,
    output logic [ENC_FRAME_W-1:0] o_enc_frame,
    output logic [DEC_FRAME_W-1:0] o_dec_frame,
    output logic [CODE_RATE_W-1:0] o_code_rate,
    output logic                   o_slice_rst_n,
    output logic                   o_en_s,
    output logic                   o_bit_valid,
    output logic                   o_busy,
`ifdef FRAME_SEQ_CNT_EN
    output logic                   o_done,
    output logic [15:0]            o_frame_cnt
`else
    output logic                   o_done
`endif
);

    localparam int CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_CYCLES - 1);

    seq_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cycleCnt_q, cycleCnt_d;
    logic                   frameReady_q, frameReady_d;
    logic                   sliceRstN_q, sliceRstN_d;
    logic                   enS_q, enS_d;
    logic                   bitValid_q, bitValid_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [ENC_FRAME_W-1:0] encFrame_q;
    logic [DEC_FRAME_W-1:0] decFrame_q;
    logic [CODE_RATE_W-1:0] codeRate_q;
    logic                   accept;
    logic                   abortHit;

    // Abort wins over a same-cycle handshake in IDLE.
    assign accept   = i_frame_valid && frameReady_q && !i_abort;
    assign abortHit = i_abort && isFrameActive(state_q);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cycleCnt_q   <= '0;
            frameReady_q <= 1'b0;
            sliceRstN_q  <= 1'b0;
            enS_q        <= 1'b0;
            bitValid_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cycleCnt_q   <= cycleCnt_d;
            frameReady_q <= frameReady_d;
            sliceRstN_q  <= sliceRstN_d;
            enS_q        <= enS_d;
            bitValid_q   <= bitValid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            encFrame_q <= '0;
            decFrame_q <= '0;
            codeRate_q <= '0;
        end else if (accept) begin
            encFrame_q <= i_enc_frame;
            decFrame_q <= i_dec_frame;
            codeRate_q <= i_code_rate;
        end
    end

    always_comb begin
        state_d    = state_q;
        cycleCnt_d = cycleCnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                state_d    = ST_RUN;
                cycleCnt_d = '0;
            end
            ST_RUN: begin
                // Counter parks on the last value rather than wrapping.
                if (cycleCnt_q == LAST_CNT) state_d = ST_DRAIN;
                else                        cycleCnt_d = cycleCnt_q + 1'b1;
            end
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (abortHit) begin
            state_d    = ST_IDLE;
            cycleCnt_d = '0;
        end
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        frameReady_d = 1'b0;
        sliceRstN_d  = 1'b1;
        enS_d        = 1'b0;
        bitValid_d   = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        case (state_d)
            ST_IDLE: begin
                frameReady_d = 1'b1;
                sliceRstN_d  = !abortHit;
            end
            ST_LOAD: begin
                sliceRstN_d = 1'b0;
                busy_d      = 1'b1;
            end
            ST_RUN: begin
                enS_d      = 1'b1;
                busy_d     = 1'b1;
                bitValid_d = (cycleCnt_d != '0);
            end
            ST_DRAIN: begin
                bitValid_d = 1'b1;
                busy_d     = 1'b1;
            end
            ST_DONE: done_d = 1'b1;
            default: frameReady_d = 1'b0;
        endcase
    end

    assign o_frame_ready = frameReady_q;
    assign o_slice_rst_n = sliceRstN_q;
    assign o_en_s        = enS_q;
    assign o_bit_valid   = bitValid_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_enc_frame   = encFrame_q;
    assign o_dec_frame   = decFrame_q;
    assign o_code_rate   = codeRate_q;

`ifdef FRAME_SEQ_CNT_EN
    logic [15:0] frameCnt_q;

    always_ff @(posedge clk) begin
        if (!rst)        frameCnt_q <= '0;
        else if (done_q) frameCnt_q <= frameCnt_q + 16'd1;
    end

    assign o_frame_cnt = frameCnt_q;
`endif

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer: per-cycle vector table plus frame-level sequences.
// Counter checks are compiled in when FRAME_SEQ_CNT_EN is defined.
module tb_frame_sequencer;
    import frame_sequencer_pkg::*;
    import param_def::*;

    localparam int BUS_W = 6 + CODE_RATE_W + ENC_FRAME_W + DEC_FRAME_W;

    // Control pattern order: {ready, sliceRstN, enS, bitValid, busy, done}
    localparam logic [5:0] P_RST   = 6'b000000;
    localparam logic [5:0] P_IDLE  = 6'b110000;
    localparam logic [5:0] P_ABRT  = 6'b100000;
    localparam logic [5:0] P_LOAD  = 6'b000010;
    localparam logic [5:0] P_RUN0  = 6'b011010;
    localparam logic [5:0] P_RUN   = 6'b011110;
    localparam logic [5:0] P_DRAIN = 6'b010110;
    localparam logic [5:0] P_DONE  = 6'b010001;

    typedef struct {
        logic       rst;
        logic       valid;
        logic       abort;
        int         drvId;
        int         reps;
        logic [5:0] ctrl;
        int         heldId;
    } vec_t;

    logic                   clk;
    logic                   rst;
    logic                   i_frame_valid;
    logic                   o_frame_ready;
    logic [CODE_RATE_W-1:0] i_code_rate;
    logic [ENC_FRAME_W-1:0] i_enc_frame;
    logic [DEC_FRAME_W-1:0] i_dec_frame;
    logic                   i_abort;
    logic [ENC_FRAME_W-1:0] o_enc_frame;
    logic [DEC_FRAME_W-1:0] o_dec_frame;
    logic [CODE_RATE_W-1:0] o_code_rate;
    logic                   o_slice_rst_n;
    logic                   o_en_s;
    logic                   o_bit_valid;
    logic                   o_busy;
    logic                   o_done;
`ifdef FRAME_SEQ_CNT_EN
    logic [15:0]            o_frame_cnt;
`endif

    int vecCount;
    int missCount;
    vec_t vecs[$];

    frame_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .i_frame_valid (i_frame_valid),
        .o_frame_ready (o_frame_ready),
        .i_code_rate   (i_code_rate),
        .i_enc_frame   (i_enc_frame),
        .i_dec_frame   (i_dec_frame),
        .i_abort       (i_abort),
        .o_enc_frame   (o_enc_frame),
        .o_dec_frame   (o_dec_frame),
        .o_code_rate   (o_code_rate),
        .o_slice_rst_n (o_slice_rst_n),
        .o_en_s        (o_en_s),
        .o_bit_valid   (o_bit_valid),
        .o_busy        (o_busy),
`ifdef FRAME_SEQ_CNT_EN
        .o_done        (o_done),
        .o_frame_cnt   (o_frame_cnt)
`else
        .o_done        (o_done)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation still running, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [ENC_FRAME_W-1:0] encOf(input int id);
        if (id == 0) return '0;
        if (id == 1) return {16{8'hA5}};
        return {4{32'hC0DE_0000 | 32'(id)}};
    endfunction

    function automatic logic [DEC_FRAME_W-1:0] decOf(input int id);
        if (id == 0) return '0;
        return {12{32'h5EED_0000 | 32'(id)}};
    endfunction

    function automatic logic [CODE_RATE_W-1:0] rateOf(input int id);
        if (id == 0) return '0;
        if (id == 2 || id == 5 || id == 9) return CODE_RATE_3;
        return CODE_RATE_2;
    endfunction

    function automatic vec_t mk(input int r, input int v, input int a, input int d,
                                input int n, input logic [5:0] c, input int h);
        vec_t x;
        x.rst    = (r != 0);
        x.valid  = (v != 0);
        x.abort  = (a != 0);
        x.drvId  = d;
        x.reps   = n;
        x.ctrl   = c;
        x.heldId = h;
        return x;
    endfunction

    function automatic logic [BUS_W-1:0] sampleDut();
        return {o_frame_ready, o_slice_rst_n, o_en_s, o_bit_valid, o_busy, o_done,
                o_code_rate, o_enc_frame, o_dec_frame};
    endfunction

    function automatic logic [BUS_W-1:0] expectBus(input logic [5:0] c, input int h);
        return {c, rateOf(h), encOf(h), decOf(h)};
    endfunction

    task automatic driveData(input int id);
        i_enc_frame = encOf(id);
        i_dec_frame = decOf(id);
        i_code_rate = rateOf(id);
    endtask

    task automatic applyStimulus(input vec_t v);
        rst           = v.rst;
        i_frame_valid = v.valid;
        i_abort       = v.abort;
        driveData(v.drvId);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [BUS_W-1:0] act,
                               input logic [BUS_W-1:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Pushes one frame from IDLE and measures done latency and enable/valid widths.
    task automatic runFrame(input int id, input string tag);
        int cyc;
        int enCnt;
        int bvCnt;
        rst           = 1'b1;
        i_abort       = 1'b0;
        i_frame_valid = 1'b1;
        driveData(id);
        @(posedge clk);
        #1;
        i_frame_valid = 1'b0;
        driveData(9);
        cyc   = 1;
        enCnt = int'(o_en_s);
        bvCnt = int'(o_bit_valid);
        while (!o_done && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
            enCnt += int'(o_en_s);
            bvCnt += int'(o_bit_valid);
        end
        checkOutput({tag, ".doneLatency"}, BUS_W'(cyc), BUS_W'(131));
        checkOutput({tag, ".enCycles"}, BUS_W'(enCnt), BUS_W'(128));
        checkOutput({tag, ".bitValidCycles"}, BUS_W'(bvCnt), BUS_W'(128));
        checkOutput({tag, ".heldData"}, {6'b0, o_code_rate, o_enc_frame, o_dec_frame},
                    expectBus(6'b0, id));
        @(posedge clk);
        #1;
        checkOutput({tag, ".donePulse"}, BUS_W'({o_done, o_frame_ready}), BUS_W'(2'b01));
    endtask

    initial begin
        vecCount      = 0;
        missCount     = 0;
        rst           = 1'b0;
        i_frame_valid = 1'b0;
        i_abort       = 1'b0;
        driveData(9);

        // Reset, then a rate-1/2 frame of 0xA5 with junk on the inputs mid-frame.
        vecs.push_back(mk(0, 0, 0, 9, 2,   P_RST,   0));
        vecs.push_back(mk(1, 0, 0, 9, 1,   P_IDLE,  0));
        vecs.push_back(mk(1, 0, 1, 9, 1,   P_IDLE,  0));
        vecs.push_back(mk(1, 1, 0, 1, 1,   P_LOAD,  1));
        vecs.push_back(mk(1, 0, 0, 9, 1,   P_RUN0,  1));
        vecs.push_back(mk(1, 0, 0, 9, 127, P_RUN,   1));
        vecs.push_back(mk(1, 0, 0, 9, 1,   P_DRAIN, 1));
        vecs.push_back(mk(1, 0, 0, 9, 1,   P_DONE,  1));
        vecs.push_back(mk(1, 0, 1, 9, 1,   P_IDLE,  1));
        // Abort beats handshake, then a rate-1/3 frame with identical timing.
        vecs.push_back(mk(1, 1, 1, 2, 1,   P_IDLE,  1));
        vecs.push_back(mk(1, 1, 0, 2, 1,   P_LOAD,  2));
        vecs.push_back(mk(1, 0, 0, 9, 1,   P_RUN0,  2));
        vecs.push_back(mk(1, 0, 0, 9, 127, P_RUN,   2));
        vecs.push_back(mk(1, 0, 0, 9, 1,   P_DRAIN, 2));
        vecs.push_back(mk(1, 0, 0, 9, 1,   P_DONE,  2));
        vecs.push_back(mk(1, 0, 0, 9, 1,   P_IDLE,  2));
        // Abort at RUN cycle 50.
        vecs.push_back(mk(1, 1, 0, 3, 1,   P_LOAD,  3));
        vecs.push_back(mk(1, 0, 0, 9, 1,   P_RUN0,  3));
        vecs.push_back(mk(1, 0, 0, 9, 50,  P_RUN,   3));
        vecs.push_back(mk(1, 0, 1, 9, 1,   P_ABRT,  3));
        vecs.push_back(mk(1, 0, 0, 9, 1,   P_IDLE,  3));
        // Valid held high: back-to-back frames only through IDLE.
        vecs.push_back(mk(1, 1, 0, 4, 1,   P_LOAD,  4));
        vecs.push_back(mk(1, 1, 0, 5, 1,   P_RUN0,  4));
        vecs.push_back(mk(1, 1, 0, 5, 127, P_RUN,   4));
        vecs.push_back(mk(1, 1, 0, 5, 1,   P_DRAIN, 4));
        vecs.push_back(mk(1, 1, 0, 5, 1,   P_DONE,  4));
        vecs.push_back(mk(1, 1, 0, 5, 1,   P_IDLE,  4));
        vecs.push_back(mk(1, 1, 0, 5, 1,   P_LOAD,  5));
        vecs.push_back(mk(1, 1, 0, 6, 1,   P_RUN0,  5));
        vecs.push_back(mk(1, 1, 0, 6, 127, P_RUN,   5));
        vecs.push_back(mk(1, 1, 0, 6, 1,   P_DRAIN, 5));
        vecs.push_back(mk(1, 1, 0, 6, 1,   P_DONE,  5));
        vecs.push_back(mk(1, 0, 0, 9, 1,   P_IDLE,  5));
        // Reset at RUN cycle 10, then abort straight out of LOAD.
        vecs.push_back(mk(1, 1, 0, 7, 1,   P_LOAD,  7));
        vecs.push_back(mk(1, 0, 0, 9, 1,   P_RUN0,  7));
        vecs.push_back(mk(1, 0, 0, 9, 10,  P_RUN,   7));
        vecs.push_back(mk(0, 0, 0, 9, 1,   P_RST,   0));
        vecs.push_back(mk(1, 0, 0, 9, 1,   P_IDLE,  0));
        vecs.push_back(mk(1, 1, 0, 8, 1,   P_LOAD,  8));
        vecs.push_back(mk(1, 0, 1, 9, 1,   P_ABRT,  8));
        vecs.push_back(mk(1, 0, 0, 9, 1,   P_IDLE,  8));

        for (int i = 0; i < vecs.size(); i++) begin
            for (int r = 0; r < vecs[i].reps; r++) begin
                applyStimulus(vecs[i]);
                checkOutput($sformatf("vec%0d.%0d", i, r), sampleDut(),
                            expectBus(vecs[i].ctrl, vecs[i].heldId));
            end
        end

        runFrame(1, "latency");

        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
`ifdef FRAME_SEQ_CNT_EN
        checkOutput("frameCntAfterReset", BUS_W'(o_frame_cnt), BUS_W'(16'd0));
`endif
        runFrame(2, "cntFrame1");
        runFrame(5, "cntFrame2");
        i_frame_valid = 1'b1;
        driveData(11);
        @(posedge clk);
        #1;
        i_frame_valid = 1'b0;
        driveData(9);
        repeat (5) @(posedge clk);
        #1;
        i_abort = 1'b1;
        @(posedge clk);
        #1;
        i_abort = 1'b0;
        checkOutput("abortOutputs",
                    BUS_W'({o_busy, o_done, o_en_s, o_bit_valid, o_slice_rst_n, o_frame_ready}),
                    BUS_W'(6'b000001));
        @(posedge clk);
        #1;
        runFrame(7, "cntFrame3");
`ifdef FRAME_SEQ_CNT_EN
        checkOutput("frameCntThree", BUS_W'(o_frame_cnt), BUS_W'(16'd3));
`else
        checkOutput("idleAfterFrames", BUS_W'({o_busy, o_frame_ready}), BUS_W'(2'b01));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
